// File: rtl/efi_pe_pkg.sv
// rtl/efi_pe_pkg.sv - shared widths, limits and stage sideband for the PE dot-product datapath
package efi_pe_pkg;

   // Sideband carried alongside each pipeline stage
   typedef struct packed {
      logic valid;
      logic first;
      logic last;
   } stage_sb_t;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

   function automatic bit is_pow2(input int value);
      return (value > 0) && ((value & (value - 1)) == 0);
   endfunction

   // Exact width of a LANES-term sum of DATA_W x DATA_W signed products
   function automatic int sum_w(input int data_w, input int lanes);
      return 2 * data_w + clog2(lanes);
   endfunction

   function automatic logic signed [127:0] acc_max(input int acc_w);
      return (128'sd1 <<< (acc_w - 1)) - 128'sd1;
   endfunction

   function automatic logic signed [127:0] acc_min(input int acc_w);
      return -(128'sd1 <<< (acc_w - 1));
   endfunction

endpackage

// File: rtl/efi_dot_product_accum_if.sv
// rtl/efi_dot_product_accum_if.sv - operand stream in, group result out, plus clock enable
interface efi_dot_product_accum_if #(
   parameter int DATA_W = 16,
   parameter int LANES  = 4,
   parameter int ACC_W  = 48
);
   logic                      ena;
   logic                      in_valid;
   logic                      in_first;
   logic                      in_last;
   logic [LANES*DATA_W-1:0]   ax;
   logic [LANES*DATA_W-1:0]   ay;
   logic                      out_valid;
   logic signed [ACC_W-1:0]   result;
   logic                      out_overflow;

   modport master (
      output ena, in_valid, in_first, in_last, ax, ay,
      input  out_valid, result, out_overflow
   );

   modport slave (
      input  ena, in_valid, in_first, in_last, ax, ay,
      output out_valid, result, out_overflow
   );
endinterface

// File: rtl/efi_signed_adder_tree.sv
// rtl/efi_signed_adder_tree.sv - registered balanced sum of LANES signed terms
module efi_signed_adder_tree
   import efi_pe_pkg::*;
#(
   parameter int LANES = 4,
   parameter int IN_W  = 32,
   parameter int OUT_W = IN_W + clog2(LANES)
) (
   input  logic                    clk0,
   input  logic                    aclr0,
   input  logic                    ena,
   input  logic [LANES*IN_W-1:0]   terms,
   output logic signed [OUT_W-1:0] sum
);

   // Heap-ordered tree: leaves at [LANES..2*LANES-1], root at [1]
   logic signed [OUT_W-1:0] node [1:2*LANES-1];

   // Pairwise reduction; OUT_W is wide enough that no level can overflow
   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         node[LANES+i] = OUT_W'($signed(terms[i*IN_W +: IN_W]));
      end
      for (int k = LANES - 1; k >= 1; k--) begin
         node[k] = node[2*k] + node[2*k+1];
      end
   end

   // Output register of the tree stage
   always_ff @(posedge clk0 or posedge aclr0) begin
      if (aclr0) begin
         sum <= '0;
      end else if (ena) begin
         sum <= node[1];
      end
   end

endmodule

// File: rtl/efi_dot_product_accum.sv
// rtl/efi_dot_product_accum.sv - signed dot-product accumulate PE; EFI_DOT_SATURATE_EN selects clamp vs wrap
module efi_dot_product_accum
   import efi_pe_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int LANES  = 4,
   parameter int ACC_W  = 48
) (
   input  logic                   clk0,
   input  logic                   aclr0,
   efi_dot_product_accum_if.slave bus
);

   localparam int PROD_W = 2 * DATA_W;
   localparam int SUM_W  = sum_w(DATA_W, LANES);

   if (ACC_W < SUM_W || !is_pow2(LANES)) begin : g_bad_cfg
      $error("efi_dot_product_accum: need ACC_W >= SUM_W and LANES a power of two");
   end

`ifdef EFI_DOT_SATURATE_EN
   localparam logic signed [ACC_W-1:0] ACC_MAX_C = ACC_W'(acc_max(ACC_W));
   localparam logic signed [ACC_W-1:0] ACC_MIN_C = ACC_W'(acc_min(ACC_W));
`endif

   logic [LANES*DATA_W-1:0]  ax_s1, ay_s1;
   logic [LANES*PROD_W-1:0]  prod_s2;
   logic signed [SUM_W-1:0]  sum_s3;
   stage_sb_t                sb_s1, sb_s2, sb_s3;

   logic signed [ACC_W-1:0]  acc, acc_base, addend, acc_raw, acc_next;
   logic                     add_ovf, grp_ovf, grp_ovf_next, emit_s4;

   // S1: capture operands; first/last only mean anything alongside valid
   always_ff @(posedge clk0 or posedge aclr0) begin
      if (aclr0) begin
         ax_s1 <= '0;
         ay_s1 <= '0;
         sb_s1 <= '0;
      end else if (bus.ena) begin
         ax_s1       <= bus.ax;
         ay_s1       <= bus.ay;
         sb_s1.valid <= bus.in_valid;
         sb_s1.first <= bus.in_valid & bus.in_first;
         sb_s1.last  <= bus.in_valid & bus.in_last;
      end
   end

   // S2: per-lane full-precision signed products
   always_ff @(posedge clk0 or posedge aclr0) begin
      if (aclr0) begin
         prod_s2 <= '0;
         sb_s2   <= '0;
      end else if (bus.ena) begin
         for (int i = 0; i < LANES; i++) begin
            prod_s2[i*PROD_W +: PROD_W] <= $signed(ax_s1[i*DATA_W +: DATA_W]) *
                                           $signed(ay_s1[i*DATA_W +: DATA_W]);
         end
         sb_s2 <= sb_s1;
      end
   end

   efi_signed_adder_tree #(
      .LANES (LANES),
      .IN_W  (PROD_W),
      .OUT_W (SUM_W)
   ) u_tree (
      .clk0  (clk0),
      .aclr0 (aclr0),
      .ena   (bus.ena),
      .terms (prod_s2),
      .sum   (sum_s3)
   );

   // S3 sideband travels in step with the tree's output register
   always_ff @(posedge clk0 or posedge aclr0) begin
      if (aclr0) begin
         sb_s3 <= '0;
      end else if (bus.ena) begin
         sb_s3 <= sb_s2;
      end
   end

   // Group accumulate with signed-overflow detection; first restarts from zero
   always_comb begin
      acc_base     = sb_s3.first ? '0 : acc;
      addend       = ACC_W'(sum_s3);
      acc_raw      = acc_base + addend;
      add_ovf      = (acc_base[ACC_W-1] == addend[ACC_W-1]) &&
                     (acc_raw[ACC_W-1] != acc_base[ACC_W-1]);
`ifdef EFI_DOT_SATURATE_EN
      if (add_ovf) begin
         acc_next = acc_base[ACC_W-1] ? ACC_MIN_C : ACC_MAX_C;
      end else begin
         acc_next = acc_raw;
      end
`else
      acc_next     = acc_raw;
`endif
      grp_ovf_next = (sb_s3.first ? 1'b0 : grp_ovf) | add_ovf;
   end

   // S4: accumulator and sticky group overflow; acc is left in place after last
   always_ff @(posedge clk0 or posedge aclr0) begin
      if (aclr0) begin
         acc     <= '0;
         grp_ovf <= 1'b0;
         emit_s4 <= 1'b0;
      end else if (bus.ena) begin
         if (sb_s3.valid) begin
            acc     <= acc_next;
            grp_ovf <= grp_ovf_next;
         end
         emit_s4 <= sb_s3.valid & sb_s3.last;
      end
   end

   // Output register: result/out_overflow hold between group-end pulses
   always_ff @(posedge clk0 or posedge aclr0) begin
      if (aclr0) begin
         bus.out_valid    <= 1'b0;
         bus.result       <= '0;
         bus.out_overflow <= 1'b0;
      end else if (bus.ena) begin
         bus.out_valid <= emit_s4;
         if (emit_s4) begin
            bus.result       <= acc;
            bus.out_overflow <= grp_ovf;
         end
      end
   end

endmodule

// File: tb/tb_efi_dot_product_accum.sv
// tb/tb_efi_dot_product_accum.sv - randomized and directed bench against a group-sum reference model
module tb_efi_dot_product_accum;

   logic clk0;
   logic rst;

   int n_checks = 0;
   int n_errors = 0;

   efi_dot_product_accum_if #(.DATA_W(16), .LANES(4), .ACC_W(48)) bus_a ();
   efi_dot_product_accum_if #(.DATA_W(16), .LANES(1), .ACC_W(33)) bus_b ();

   efi_dot_product_accum #(.DATA_W(16), .LANES(4), .ACC_W(48)) dut_a (
      .clk0  (clk0),
      .aclr0 (rst),
      .bus   (bus_a)
   );

   efi_dot_product_accum #(.DATA_W(16), .LANES(1), .ACC_W(33)) dut_b (
      .clk0  (clk0),
      .aclr0 (rst),
      .bus   (bus_b)
   );

   initial begin
      clk0 = 1'b0;
      forever #5 clk0 = ~clk0;
   end

   // Reference model: group sums in plain integer arithmetic, 4 enabled edges of delay
   typedef struct {
      bit     emit;
      longint val;
      bit     ovf;
   } exp_t;

   exp_t   dl [2][4];
   longint m_acc [2];
   bit     m_ovf [2];
   bit     e_valid [2];
   longint e_res [2];
   bit     e_ovf [2];

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         for (int k = 0; k < 4; k++) dl[d][k] = '{emit: 1'b0, val: 0, ovf: 1'b0};
         m_acc[d]   = 0;
         m_ovf[d]   = 1'b0;
         e_valid[d] = 1'b0;
         e_res[d]   = 0;
         e_ovf[d]   = 1'b0;
      end
   endtask

   task automatic model_step(input int d, input int lanes, input int acc_w,
                             input bit v, input bit f, input bit l,
                             input logic [63:0] x, input logic [63:0] y);
      exp_t   out_item;
      exp_t   new_item;
      longint s;
      longint t;
      longint one;
      longint vmax;
      longint vmin;
      one      = 1;
      vmax     = (one << (acc_w - 1)) - 1;
      vmin     = -vmax - 1;
      out_item = dl[d][3];
      for (int k = 3; k > 0; k--) dl[d][k] = dl[d][k-1];
      new_item = '{emit: 1'b0, val: 0, ovf: 1'b0};
      if (v) begin
         s = 0;
         for (int i = 0; i < lanes; i++) begin
            s += longint'($signed(x[i*16 +: 16])) * longint'($signed(y[i*16 +: 16]));
         end
         if (f) begin
            m_acc[d] = 0;
            m_ovf[d] = 1'b0;
         end
         t = m_acc[d] + s;
         if (t > vmax) begin
            m_ovf[d] = 1'b1;
`ifdef EFI_DOT_SATURATE_EN
            t = vmax;
`else
            t = t - (one << acc_w);
`endif
         end else if (t < vmin) begin
            m_ovf[d] = 1'b1;
`ifdef EFI_DOT_SATURATE_EN
            t = vmin;
`else
            t = t + (one << acc_w);
`endif
         end
         m_acc[d] = t;
         if (l) new_item = '{emit: 1'b1, val: m_acc[d], ovf: m_ovf[d]};
      end
      dl[d][0]   = new_item;
      e_valid[d] = out_item.emit;
      if (out_item.emit) begin
         e_res[d] = out_item.val;
         e_ovf[d] = out_item.ovf;
      end
   endtask

   // Advance the model on every enabled edge; reset clears it at once
   always @(posedge clk0 or posedge rst) begin
      if (rst) begin
         model_reset();
      end else begin
         if (bus_a.ena) model_step(0, 4, 48, bus_a.in_valid, bus_a.in_first, bus_a.in_last,
                                   bus_a.ax, bus_a.ay);
         if (bus_b.ena) model_step(1, 1, 33, bus_b.in_valid, bus_b.in_first, bus_b.in_last,
                                   64'(bus_b.ax), 64'(bus_b.ay));
      end
   end

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Compare every output of both instances on every falling edge
   always @(negedge clk0) begin
      chk("a_out_valid", longint'(bus_a.out_valid), longint'(e_valid[0]));
      chk("a_result", longint'($signed(bus_a.result)), e_res[0]);
      chk("a_out_overflow", longint'(bus_a.out_overflow), longint'(e_ovf[0]));
      chk("b_out_valid", longint'(bus_b.out_valid), longint'(e_valid[1]));
      chk("b_result", longint'($signed(bus_b.result)), e_res[1]);
      chk("b_out_overflow", longint'(bus_b.out_overflow), longint'(e_ovf[1]));
   end

   function automatic logic [63:0] pack4(input int a0, input int a1, input int a2, input int a3);
      logic [63:0] r;
      r[15:0]  = a0[15:0];
      r[31:16] = a1[15:0];
      r[47:32] = a2[15:0];
      r[63:48] = a3[15:0];
      return r;
   endfunction

   task automatic tick();
      @(negedge clk0);
      #1;
   endtask

   task automatic send_a(input bit f, input bit l, input logic [63:0] x, input logic [63:0] y);
      tick();
      bus_a.in_valid = 1'b1;
      bus_a.in_first = f;
      bus_a.in_last  = l;
      bus_a.ax       = x;
      bus_a.ay       = y;
   endtask

   task automatic send_b(input bit f, input bit l, input int x, input int y);
      tick();
      bus_b.in_valid = 1'b1;
      bus_b.in_first = f;
      bus_b.in_last  = l;
      bus_b.ax       = x[15:0];
      bus_b.ay       = y[15:0];
   endtask

   task automatic idle();
      tick();
      bus_a.in_valid = 1'b0;
      bus_a.in_first = 1'b0;
      bus_a.in_last  = 1'b0;
      bus_b.in_valid = 1'b0;
      bus_b.in_first = 1'b0;
      bus_b.in_last  = 1'b0;
   endtask

   task automatic wait_res(input int d, input longint er, input bit eo, input string name);
      bit found = 1'b0;
      for (int i = 0; i < 40 && !found; i++) begin
         @(negedge clk0);
         if ((d == 0) ? bus_a.out_valid : bus_b.out_valid) found = 1'b1;
      end
      if (!found) begin
         n_checks++;
         n_errors++;
         $display("FAIL %s: out_valid not seen within 40 cycles", name);
      end else if (d == 0) begin
         chk({name, "_result"}, longint'($signed(bus_a.result)), er);
         chk({name, "_ovf"}, longint'(bus_a.out_overflow), longint'(eo));
         chk({name, "_model"}, e_res[0], er);
      end else begin
         chk({name, "_result"}, longint'($signed(bus_b.result)), er);
         chk({name, "_ovf"}, longint'(bus_b.out_overflow), longint'(eo));
         chk({name, "_model"}, e_res[1], er);
      end
   endtask

   initial begin
      int prev;
      int rises;
      rst            = 1'b1;
      bus_a.ena      = 1'b1;
      bus_a.in_valid = 1'b0;
      bus_a.in_first = 1'b0;
      bus_a.in_last  = 1'b0;
      bus_a.ax       = '0;
      bus_a.ay       = '0;
      bus_b.ena      = 1'b1;
      bus_b.in_valid = 1'b0;
      bus_b.in_first = 1'b0;
      bus_b.in_last  = 1'b0;
      bus_b.ax       = '0;
      bus_b.ay       = '0;
      model_reset();
      repeat (3) tick();
      chk("reset_a_out_valid", longint'(bus_a.out_valid), 0);
      chk("reset_a_result", longint'($signed(bus_a.result)), 0);
      rst = 1'b0;

      // Basic dot product, single-vector group
      send_a(1, 1, pack4(1, 2, 3, 4), pack4(5, 6, 7, 8));
      idle();
      wait_res(0, 70, 0, "basic70");
      @(negedge clk0);
      chk("basic70_single_pulse", longint'(bus_a.out_valid), 0);
      chk("basic70_hold", longint'($signed(bus_a.result)), 70);

      // Operand extremes
      send_a(1, 1, pack4(-32768, -32768, -32768, -32768), pack4(-32768, -32768, -32768, -32768));
      idle();
      wait_res(0, 64'sd4294967296, 0, "ext_pos");
      send_a(1, 1, pack4(-32768, -32768, -32768, -32768), pack4(32767, 32767, 32767, 32767));
      idle();
      wait_res(0, -64'sd4294836224, 0, "ext_neg");

      // Three-vector group then a back-to-back single-vector group
      send_a(1, 0, pack4(10, 0, 0, 0), pack4(1, 0, 0, 0));
      send_a(0, 0, pack4(-3, 0, 0, 0), pack4(1, 0, 0, 0));
      send_a(0, 1, pack4(25, 25, 25, 25), pack4(1, 1, 1, 1));
      send_a(1, 1, pack4(7, 0, 0, 0), pack4(1, 0, 0, 0));
      idle();
      wait_res(0, 107, 0, "grp107");
      wait_res(0, 7, 0, "grp7");

      // Clock enable toggling through a two-vector group
      send_a(1, 0, pack4(1, 2, 3, 4), pack4(5, 6, 7, 8));
      tick();
      bus_a.ena = 1'b0;
      send_a(0, 1, pack4(100, 0, 0, 0), pack4(3, 0, 0, 0));
      bus_a.ena = 1'b1;
      idle();
      bus_a.ena = 1'b0;
      prev  = 0;
      rises = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk0);
         if (bus_a.out_valid && prev == 0) begin
            rises++;
            chk("ena_result", longint'($signed(bus_a.result)), 370);
         end
         prev = int'(bus_a.out_valid);
         #1 bus_a.ena = ~bus_a.ena;
      end
      chk("ena_pulse_count", rises, 1);
      tick();
      bus_a.ena = 1'b1;
      repeat (3) tick();

      // Asynchronous reset in the middle of a group
      send_a(1, 0, pack4(9, 9, 9, 9), pack4(9, 9, 9, 9));
      send_a(0, 0, pack4(3, 3, 3, 3), pack4(3, 3, 3, 3));
      idle();
      rst = 1'b1;
      #1;
      chk("aclr_out_valid", longint'(bus_a.out_valid), 0);
      chk("aclr_result", longint'($signed(bus_a.result)), 0);
      chk("aclr_out_overflow", longint'(bus_a.out_overflow), 0);
      tick();
      rst = 1'b0;
      rises = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk0);
         if (bus_a.out_valid) rises++;
      end
      chk("aclr_no_emit", rises, 0);
      send_a(1, 1, pack4(5, 0, 0, 0), pack4(1, 0, 0, 0));
      idle();
      wait_res(0, 5, 0, "after_aclr5");

      // Narrow accumulator overflow on the single-lane instance
      send_b(1, 0, 32767, 32767);
      send_b(0, 0, 32767, 32767);
      send_b(0, 0, 32767, 32767);
      send_b(0, 0, 32767, 32767);
      send_b(0, 1, 32767, 32767);
      idle();
`ifdef EFI_DOT_SATURATE_EN
      wait_res(1, 64'sd4294967295, 1, "b_overflow");
`else
      wait_res(1, -64'sd3221553147, 1, "b_overflow");
`endif
      send_b(1, 1, 1, 1);
      idle();
      wait_res(1, 1, 0, "b_first_clears");

      // Randomized traffic on both instances, checked cycle by cycle
      for (int c = 0; c < 3000; c++) begin
         tick();
         if ($urandom_range(0, 499) == 0) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
         end
         bus_a.ena      = ($urandom_range(0, 3) != 0);
         bus_a.in_valid = ($urandom_range(0, 3) != 0);
         bus_a.in_first = ($urandom_range(0, 3) == 0);
         bus_a.in_last  = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 9) == 0) begin
            bus_a.ax = {4{16'h8000}};
            bus_a.ay = {4{16'h8000}};
         end else begin
            bus_a.ax = {$urandom(), $urandom()};
            bus_a.ay = {$urandom(), $urandom()};
         end
         bus_b.ena      = ($urandom_range(0, 3) != 0);
         bus_b.in_valid = ($urandom_range(0, 3) != 0);
         bus_b.in_first = ($urandom_range(0, 5) == 0);
         bus_b.in_last  = ($urandom_range(0, 3) == 0);
         bus_b.ax       = 16'($urandom());
         bus_b.ay       = 16'($urandom());
      end
      bus_a.ena = 1'b1;
      bus_b.ena = 1'b1;
      idle();
      repeat (8) tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/efi_dot_product_accum.md
# efi_dot_product_accum

Parametrised signed dot-product-and-accumulate processing element for the CNN PE array. It generalises the fixed two-pair 16x16 sum-of-products into LANES signed products of DATA_W bits. It adds a streaming accumulator with group framing (first/last), a valid pipeline, a clock enable and sticky overflow detection. It sits between the PE feature/weight operand buffers and the PE output collector, and produces one result per accumulation group.

## Interface
- DATA_W, 16, signed operand width per lane (2..27)
- LANES, 4, number of x*y product pairs per vector (power of two, 1..16)
- ACC_W, 48, accumulator/result width; must be >= 2*DATA_W+clog2(LANES)
- clk0  in  1  clock; all state on rising edge
- aclr0  in  1  asynchronous active-high reset
- ena  in  1  clock enable; low freezes every pipeline stage, including valid/first/last
- in_valid  in  1  input vector present this cycle (no backpressure; always accepted when ena=1)
- in_first  in  1  qualifies in_valid: vector starts a new group, accumulator restarts from zero
- in_last  in  1  qualifies in_valid: vector closes the group, result emitted
- ax  in  LANES*DATA_W  signed x operands, lane i at [i*DATA_W +: DATA_W]
- ay  in  LANES*DATA_W  signed y operands, same packing
- out_valid  out  1  one-cycle pulse: result holds a completed group
- result  out  ACC_W  signed group sum; holds value between pulses
- out_overflow  out  1  group overflowed ACC_W; valid with out_valid

## Operation
- Per accepted vector: S = sum over i of ax[i]*ay[i]. Products are 2*DATA_W signed. The tree sum is SUM_W = 2*DATA_W+clog2(LANES) signed and exact, with no overflow possible. S is sign-extended to ACC_W.
- Accumulator: acc_next = (first ? 0 : acc) + S. in_valid without in_first continues the current group. After reset, acc = 0, so an unframed stream starts from zero.
- in_first and in_last together: a single-vector group; result = S.
- On last: result <= acc_next, out_overflow <= group overflow, out_valid pulses. The accumulator value is left in place; the next group must start with first.
- Overflow: the signed add overflows when both operands share a sign and the sum sign differs. The flag is sticky within the group and cleared by first.
- in_first/in_last without in_valid are ignored.
- No FSM. Pipeline state consists of the valid/first/last shadow bits per stage.

## Timing
- Stages: S1 input register, S2 lane products, S3 adder tree, S4 accumulator + output register.
- Latency: a vector accepted at edge t (ena=1) yields out_valid at edge t+4, counting enabled edges only.
- Throughput: one vector per enabled cycle, groups back-to-back. A last at cycle t followed by a first at t+1 is legal and produces independent results.
- ena=0: all registers hold, out_valid holds its value, and no duplicate emission occurs when ena rises again.
- Reset (aclr0=1, any time including mid-group): all stages, acc, result, out_valid and out_overflow go to 0 immediately. In-flight vectors are discarded. The first vector after release accumulates from 0.

## Configuration
- EFI_DOT_SATURATE_EN defined: on accumulator overflow, acc and result clamp to the signed ACC_W max/min according to the direction of the overflow. Further adds continue from the clamped value. out_overflow is still set.
- Not defined: two's-complement wrap modulo 2^ACC_W, with out_overflow as the only indication.

## Structure
- Package efi_pe_pkg holds:
  - the clog2 function
  - the SUM_W derivation
  - ACC_MAX/ACC_MIN constants (as functions of ACC_W)
  - the per-stage sideband struct (valid, first, last)
- Elaboration-time check in the top: ACC_W >= SUM_W and LANES is a power of two.
- One sub-module: efi_signed_adder_tree (parametrised LANES, input width 2*DATA_W, one register at output). It forms S3.

## Test plan
- LANES=4, DATA_W=16; single group first+last with ax={1,2,3,4}, ay={5,6,7,8} -> result=70 at t+4, out_valid for one cycle, out_overflow=0.
- Extremes: all ax=-32768, ay=-32768, single group -> result=4*2^30=4294967296. Same with ay=+32767 -> result=-4294836224.
- Three-vector group with per-vector sums 10, -3, 100, directly followed by a single-vector group with sum 7 -> results 107 then 7 on consecutive group ends, with no carry-over.
- ena toggled 0/1 every other cycle during a two-vector group -> same result as the continuous run; out_valid exactly once; latency counts only enabled edges.
- ACC_W=33, DATA_W=16, LANES=1; repeated 32767*32767 products without last until sum > 2^32-1 -> without the macro, result wraps and out_overflow=1. With EFI_DOT_SATURATE_EN, result=2^32-1 and out_overflow=1. The next first clears out_overflow.
- aclr0 pulsed mid-group after two vectors -> outputs 0 immediately, no out_valid. A later first+last vector with sum 5 gives result=5.
